ex_stage: RTL and testbench

- Execute stage of the 5-stage pipeline. It sits between the ID stage and the mem stage and drives the mem stage's inputs directly: mem_write, mem_read, mem_to_reg, addr_in, addr_reg_in and write_data.
- It decodes a 4-bit opcode, runs single-cycle ALU operations, and runs an iterative multi-cycle multiply that stalls upstream.
- Results are registered into an EX/MEM pipeline register.

---
 rtl/ex_stage_pkg.sv | 27 ++
 rtl/ex_stage_if.sv | 35 +++
 rtl/ex_stage_mul.sv | 40 ++++
 rtl/ex_stage.sv | 87 ++++++++
 tb/tb_ex_stage.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: widths, opcode encodings and the EX/MEM register layout shared with the mem stage
package ex_stage_pkg;
  localparam int D_SIZE = 32;
  localparam int ADDR_LINE_MEM = 8;
  localparam int ADDR_LINE_REG = 5;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_MUL  = 4'd6,
    OP_LDW  = 4'd7,
    OP_STW  = 4'd8,
    OP_ADDI = 4'd9
  } opcode_t;
  typedef enum logic {IDLE, MUL} state_t;
  typedef struct packed {
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic [ADDR_LINE_MEM-1:0] addr_in;
    logic [ADDR_LINE_REG-1:0] addr_reg_in;
    logic [D_SIZE-1:0] write_data;
  } ex_mem_t;
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID-side instruction bus and mem-side control/data bus of the execute stage; EX_FWD_EN adds rs_addr/rt_addr
interface ex_stage_if;
  import ex_stage_pkg::*;
  logic in_valid;
  logic [3:0] opcode;
  logic [D_SIZE-1:0] opa;
  logic [D_SIZE-1:0] opb;
  logic [D_SIZE-1:0] imm;
  logic [ADDR_LINE_REG-1:0] rd_addr;
`ifdef EX_FWD_EN
  logic [ADDR_LINE_REG-1:0] rs_addr;
  logic [ADDR_LINE_REG-1:0] rt_addr;
`endif
  logic stall;
  logic mem_write;
  logic mem_read;
  logic mem_to_reg;
  logic [ADDR_LINE_MEM-1:0] addr_in;
  logic [ADDR_LINE_REG-1:0] addr_reg_in;
  logic [D_SIZE-1:0] write_data;
  modport slave (
    input in_valid, opcode, opa, opb, imm, rd_addr,
`ifdef EX_FWD_EN
    input rs_addr, rt_addr,
`endif
    output stall, mem_write, mem_read, mem_to_reg, addr_in, addr_reg_in, write_data
  );
  modport master (
    output in_valid, opcode, opa, opb, imm, rd_addr,
`ifdef EX_FWD_EN
    output rs_addr, rt_addr,
`endif
    input stall, mem_write, mem_read, mem_to_reg, addr_in, addr_reg_in, write_data
  );
endinterface

// File: rtl/ex_stage_mul.sv
// ex_mul: iterative shift-add multiplier, one step per cycle for D_SIZE cycles, low D_SIZE product bits
module ex_mul
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [D_SIZE-1:0] a,
  input  logic [D_SIZE-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [D_SIZE-1:0] product
);
  localparam int CW = $clog2(D_SIZE);
  logic [D_SIZE-1:0] mcand, mplier, acc;
  logic [CW-1:0] cnt;
  // product is the accumulator after this cycle's step, valid when done is high
  assign product = mplier[0] ? acc + mcand : acc;
  assign done = busy && cnt == CW'(D_SIZE - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      mcand <= a;
      mplier <= b;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with ALU decode, iterative MUL with upstream stall and EX/MEM register; EX_FWD_EN enables EX->EX forwarding
module ex_stage
  import ex_stage_pkg::*;
(
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave bus
);
  state_t state, state_nxt;
  ex_mem_t ex_mem, nxt;
  logic [D_SIZE-1:0] opa_f, opb_f, ea, alu, product;
  logic [ADDR_LINE_REG-1:0] rd_q;
  logic start, mul_busy, mul_done;
`ifdef EX_FWD_EN
  logic fwd_ok;
  // loads carry no data yet in EX/MEM, so only ALU/MUL results are forwarded
  assign fwd_ok = ex_mem.mem_to_reg && !ex_mem.mem_read && ex_mem.addr_reg_in != '0;
  assign opa_f = fwd_ok && ex_mem.addr_reg_in == bus.rs_addr ? ex_mem.write_data : bus.opa;
  assign opb_f = fwd_ok && ex_mem.addr_reg_in == bus.rt_addr ? ex_mem.write_data : bus.opb;
`else
  assign opa_f = bus.opa;
  assign opb_f = bus.opb;
`endif
  assign ea = opa_f + bus.imm;
  assign start = state == IDLE && bus.in_valid && bus.opcode == OP_MUL && !mul_busy;
  assign alu = bus.opcode == OP_ADD ? opa_f + opb_f :
               bus.opcode == OP_SUB ? opa_f - opb_f :
               bus.opcode == OP_AND ? opa_f & opb_f :
               bus.opcode == OP_OR  ? opa_f | opb_f :
               bus.opcode == OP_XOR ? opa_f ^ opb_f :
               bus.opcode == OP_ADDI ? ea : '0;
  ex_mul u_mul (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(opa_f),
    .b(opb_f),
    .busy(mul_busy),
    .done(mul_done),
    .product(product)
  );
  always_comb begin
    nxt = '0;
    state_nxt = start ? MUL : state == MUL && mul_done ? IDLE : state;
    if (state == MUL && mul_done) begin
      nxt.mem_to_reg = 1'b1;
      nxt.addr_reg_in = rd_q;
      nxt.write_data = product;
    end else if (state == IDLE && bus.in_valid)
      case (bus.opcode)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
          nxt.mem_to_reg = 1'b1;
          nxt.addr_reg_in = bus.rd_addr;
          nxt.write_data = alu;
        end
        OP_LDW: begin
          nxt.mem_read = 1'b1;
          nxt.mem_to_reg = 1'b1;
          nxt.addr_in = ea[ADDR_LINE_MEM-1:0];
          nxt.addr_reg_in = bus.rd_addr;
        end
        OP_STW: begin
          nxt.mem_write = 1'b1;
          nxt.addr_in = ea[ADDR_LINE_MEM-1:0];
          nxt.write_data = opb_f;
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ex_mem <= '0;
      rd_q <= '0;
    end else begin
      state <= state_nxt;
      ex_mem <= nxt;
      if (start) rd_q <= bus.rd_addr;
    end
  assign bus.stall = state == MUL;
  assign bus.mem_write = ex_mem.mem_write;
  assign bus.mem_read = ex_mem.mem_read;
  assign bus.mem_to_reg = ex_mem.mem_to_reg;
  assign bus.addr_in = ex_mem.addr_in;
  assign bus.addr_reg_in = ex_mem.addr_reg_in;
  assign bus.write_data = ex_mem.write_data;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage (forwarding scenario built only with EX_FWD_EN)
module tb_ex_stage;
  import ex_stage_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  ex_stage_if bus ();
  ex_stage dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [48:0] obs;
  assign obs = {bus.stall, bus.mem_write, bus.mem_read, bus.mem_to_reg, bus.addr_in, bus.addr_reg_in, bus.write_data};
  localparam logic [48:0] BUBBLE_STALL = {1'b1, 48'd0};
  typedef struct {
    logic v;
    logic [3:0] op;
    logic [31:0] a, b, i;
    logic [4:0] rd;
    logic [48:0] exp;
    string name;
  } vec_t;

  function automatic logic [48:0] e(input logic st, mw, mr, m2r, input logic [7:0] ad,
                                    input logic [4:0] rd, input logic [31:0] wd);
    return {st, mw, mr, m2r, ad, rd, wd};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, b, i, input logic [4:0] rd);
    bus.in_valid = v;
    bus.opcode = op;
    bus.opa = a;
    bus.opb = b;
    bus.imm = i;
    bus.rd_addr = rd;
  endtask

  task automatic test_reset;
    drive(1, OP_ADD, 1, 2, 0, 3);
    #1;
    checks++;
    if (obs !== 49'd0) begin failures++; $display("FAIL reset_hold obs=%h exp=%h", obs, 49'd0); end
    drive(0, OP_NOP, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b1;
    tick;
    checks++;
    if (obs !== 49'd0) begin failures++; $display("FAIL reset_release obs=%h exp=%h", obs, 49'd0); end
  endtask

  task automatic test_alu;
    vec_t v[11];
    v = '{
      '{1, OP_ADD, 32'd5, 32'd7, 32'd0, 5'd3, e(0,0,0,1,8'h0,5'd3,32'd12), "add"},
      '{1, OP_SUB, 32'd0, 32'd1, 32'd0, 5'd4, e(0,0,0,1,8'h0,5'd4,32'hFFFFFFFF), "sub_wrap"},
      '{1, OP_AND, 32'hF0F0, 32'hFF00, 32'd0, 5'd5, e(0,0,0,1,8'h0,5'd5,32'hF000), "and"},
      '{1, OP_OR, 32'hF0F0, 32'hFF00, 32'd0, 5'd6, e(0,0,0,1,8'h0,5'd6,32'hFFF0), "or"},
      '{1, OP_XOR, 32'hF0F0, 32'hFF00, 32'd0, 5'd7, e(0,0,0,1,8'h0,5'd7,32'h0FF0), "xor"},
      '{1, OP_ADDI, 32'd10, 32'd99, 32'hFFFFFFFD, 5'd8, e(0,0,0,1,8'h0,5'd8,32'd7), "addi_neg"},
      '{1, 4'd12, 32'd1, 32'd1, 32'd1, 5'd3, 49'd0, "illegal12"},
      '{1, OP_ADD, 32'hFFFFFFFF, 32'd2, 32'd0, 5'd1, e(0,0,0,1,8'h0,5'd1,32'd1), "add_wrap"},
      '{1, OP_NOP, 32'd1, 32'd1, 32'd1, 5'd3, 49'd0, "nop"},
      '{1, OP_XOR, 32'd3, 32'd5, 32'd0, 5'd2, e(0,0,0,1,8'h0,5'd2,32'd6), "xor2"},
      '{0, OP_ADD, 32'd5, 32'd7, 32'd0, 5'd3, 49'd0, "invalid"}
    };
    foreach (v[k]) begin
      drive(v[k].v, v[k].op, v[k].a, v[k].b, v[k].i, v[k].rd);
      tick;
      checks++;
      if (obs !== v[k].exp) begin failures++; $display("FAIL %s obs=%h exp=%h", v[k].name, obs, v[k].exp); end
    end
    drive(0, OP_NOP, 0, 0, 0, 0);
  endtask

  task automatic test_mem;
    vec_t v[4];
    v = '{
      '{1, OP_STW, 32'h10, 32'hAB, 32'd4, 5'd0, e(0,1,0,0,8'h14,5'd0,32'hAB), "stw"},
      '{1, OP_LDW, 32'h10, 32'hAB, 32'd4, 5'd2, e(0,0,1,1,8'h14,5'd2,32'd0), "ldw"},
      '{1, OP_STW, 32'h1FF, 32'h55, 32'd2, 5'd0, e(0,1,0,0,8'h01,5'd0,32'h55), "stw_trunc"},
      '{1, OP_LDW, 32'h20, 32'd0, 32'hFFFFFFFF, 5'd31, e(0,0,1,1,8'h1F,5'd31,32'd0), "ldw_negimm"}
    };
    foreach (v[k]) begin
      drive(v[k].v, v[k].op, v[k].a, v[k].b, v[k].i, v[k].rd);
      tick;
      checks++;
      if (obs !== v[k].exp) begin failures++; $display("FAIL %s obs=%h exp=%h", v[k].name, obs, v[k].exp); end
    end
    drive(0, OP_NOP, 0, 0, 0, 0);
  endtask

  task automatic test_mul;
    logic [31:0] ma[2] = '{32'd3, 32'd0};
    logic [31:0] mb[2] = '{32'd7, 32'd5};
    logic [4:0] mrd[2] = '{5'd9, 5'd11};
    logic [31:0] mexp[2] = '{32'd21, 32'd0};
    logic [31:0] ha[2] = '{32'd1, 32'd2};
    logic [31:0] hb[2] = '{32'd1, 32'd3};
    logic [4:0] hrd[2] = '{5'd10, 5'd12};
    logic [31:0] hexp[2] = '{32'd2, 32'd5};
    int n;
    for (int k = 0; k < 2; k++) begin
      drive(1, OP_MUL, ma[k], mb[k], 0, mrd[k]);
      tick;
      n = 1;
      checks++;
      if (obs !== BUBBLE_STALL) begin failures++; $display("FAIL mul_accept obs=%h exp=%h", obs, BUBBLE_STALL); end
      drive(1, OP_ADD, ha[k], hb[k], 0, hrd[k]);
      for (int c = 0; c < 40 && bus.stall; c++) begin
        tick;
        if (bus.stall) begin
          n++;
          checks++;
          if (obs !== BUBBLE_STALL) begin failures++; $display("FAIL mul_bubble obs=%h exp=%h", obs, BUBBLE_STALL); end
        end
      end
      checks++;
      if (n !== 32) begin failures++; $display("FAIL mul_stall_len obs=%0d exp=32", n); end
      checks++;
      if (obs !== e(0,0,0,1,8'h0,mrd[k],mexp[k])) begin
        failures++; $display("FAIL mul_product obs=%h exp=%h", obs, e(0,0,0,1,8'h0,mrd[k],mexp[k]));
      end
      tick;
      checks++;
      if (obs !== e(0,0,0,1,8'h0,hrd[k],hexp[k])) begin
        failures++; $display("FAIL mul_held_add obs=%h exp=%h", obs, e(0,0,0,1,8'h0,hrd[k],hexp[k]));
      end
      drive(0, OP_NOP, 0, 0, 0, 0);
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int n;
    drive(1, OP_MUL, 32'hFFFFFFFF, 32'd2, 0, 5'd13);
    tick;
    drive(1, OP_MUL, 32'd3, 32'd5, 0, 5'd14);
    n = 1;
    for (int c = 0; c < 40 && bus.stall; c++) begin
      tick;
      if (bus.stall) n++;
    end
    checks++;
    if (n !== 32) begin failures++; $display("FAIL b2b_stall_len obs=%0d exp=32", n); end
    checks++;
    if (obs !== e(0,0,0,1,8'h0,5'd13,32'hFFFFFFFE)) begin
      failures++; $display("FAIL mul_wrap obs=%h exp=%h", obs, e(0,0,0,1,8'h0,5'd13,32'hFFFFFFFE));
    end
    tick;
    checks++;
    if (obs !== BUBBLE_STALL) begin failures++; $display("FAIL b2b_accept obs=%h exp=%h", obs, BUBBLE_STALL); end
    drive(0, OP_NOP, 0, 0, 0, 0);
    repeat (9) tick;
    checks++;
    if (bus.stall !== 1'b1) begin failures++; $display("FAIL b2b_stall10 obs=%b exp=1", bus.stall); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 49'd0) begin failures++; $display("FAIL async_reset obs=%h exp=%h", obs, 49'd0); end
    drive(1, OP_ADD, 32'd2, 32'd2, 0, 5'd15);
    @(negedge clk) reset = 1'b1;
    tick;
    checks++;
    if (obs !== e(0,0,0,1,8'h0,5'd15,32'd4)) begin
      failures++; $display("FAIL add_after_reset obs=%h exp=%h", obs, e(0,0,0,1,8'h0,5'd15,32'd4));
    end
    drive(1, OP_MUL, 32'd6, 32'd7, 0, 5'd16);
    tick;
    drive(0, OP_NOP, 0, 0, 0, 0);
    for (int c = 0; c < 40 && bus.stall; c++) tick;
    checks++;
    if (obs !== e(0,0,0,1,8'h0,5'd16,32'd42)) begin
      failures++; $display("FAIL mul_after_reset obs=%h exp=%h", obs, e(0,0,0,1,8'h0,5'd16,32'd42));
    end
    tick;
  endtask

`ifdef EX_FWD_EN
  task automatic test_fwd;
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    drive(1, OP_ADD, 32'd4, 32'd4, 0, 5'd1);
    tick;
    bus.rs_addr = 5'd1;
    drive(1, OP_ADD, 32'd0, 32'd1, 0, 5'd2);
    tick;
    checks++;
    if (obs !== e(0,0,0,1,8'h0,5'd2,32'd9)) begin
      failures++; $display("FAIL fwd_alu obs=%h exp=%h", obs, e(0,0,0,1,8'h0,5'd2,32'd9));
    end
    bus.rs_addr = 5'd0;
    drive(1, OP_LDW, 32'd0, 32'd0, 0, 5'd1);
    tick;
    bus.rs_addr = 5'd1;
    drive(1, OP_ADD, 32'd0, 32'd1, 0, 5'd2);
    tick;
    checks++;
    if (obs !== e(0,0,0,1,8'h0,5'd2,32'd1)) begin
      failures++; $display("FAIL fwd_ldw_blocked obs=%h exp=%h", obs, e(0,0,0,1,8'h0,5'd2,32'd1));
    end
    bus.rs_addr = 5'd0;
    drive(0, OP_NOP, 0, 0, 0, 0);
    tick;
  endtask
`endif

  initial begin
`ifdef EX_FWD_EN
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
`endif
    drive(0, OP_NOP, 0, 0, 0, 0);
    test_reset;
    test_alu;
    test_mem;
    test_mul;
    test_back_to_back;
`ifdef EX_FWD_EN
    test_fwd;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end
endmodule
